// File: rtl/d_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// d_stall_ctrl_pkg
// Shared constants and types for the decode-stage stall/forward controller.
//   TUSE_NONE          : d_tuse_* value meaning "operand not read".
//   fwd_sel_e          : comparator source select (GRF / from E / from M).
//   MD_MULT_CYC/DIV_CYC: multiply/divide occupancy after the issue cycle.
//   stage_t            : shadow of one pipeline stage (dest reg, tnew).
//   tnew_dec()         : saturating decrement of tnew when moving E -> M.
// -----------------------------------------------------------------------------
package d_stall_ctrl_pkg;

    localparam logic [1:0] TUSE_NONE   = 2'd3;
    localparam logic [3:0] MD_MULT_CYC = 4'd5;
    localparam logic [3:0] MD_DIV_CYC  = 4'd10;

    typedef enum logic [1:0] {
        FWD_GRF = 2'd0,
        FWD_E   = 2'd1,
        FWD_M   = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic [4:0] wa;
        logic [1:0] tnew;
    } stage_t;

    // A result one stage further down is one cycle closer to being ready;
    // once ready it stays ready (never wraps back to 3).
    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/d_stall_ctrl_md_busy_ctr.sv
// -----------------------------------------------------------------------------
// md_busy_ctr
// Tracks occupancy of the multiply/divide unit.
//   clk   in  : clock, rising edge
//   reset in  : asynchronous active-low reset, abandons any running operation
//   start in  : mult/div issues from E this cycle
//   div   in  : qualifies start, 1 = divide, 0 = multiply
//   busy  out : unit occupied (counter running, or an issue this cycle)
// A new start while the counter is running restarts it with the new latency.
// -----------------------------------------------------------------------------
module md_busy_ctr
    import d_stall_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    output logic busy
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = div ? MD_DIV_CYC : MD_MULT_CYC;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The issue cycle itself already counts as busy so a dependent
    // instruction in D stalls with zero latency.
    assign busy = (cnt_q != 4'd0) | start;

endmodule

// File: rtl/d_stall_ctrl.sv
// -----------------------------------------------------------------------------
// d_stall_ctrl
// Decode-stage hazard detection and branch-comparator forwarding control using
// Tuse/Tnew bookkeeping on shadow copies of the E and M stages.
//   clk        in   : clock, rising edge
//   reset      in   : asynchronous active-low reset
//   d_rs/d_rt  in 5 : D-stage source registers (comparator srcA/srcB)
//   d_tuse_rs/rt in 2: cycles until operand needed (3 = not used)
//   d_wa       in 5 : D-stage destination register
//   d_tnew     in 2 : cycles after entering E until result forwardable
//   d_md       in   : D instruction uses the mult/div unit
//   e_md_start in   : mult/div issues from E this cycle
//   e_md_div   in   : qualifies e_md_start, 1 = div
//   stall      out  : freeze PC/F/D and bubble E (combinational)
//   fwd_cmp_a/b out 2: comparator source select (0 GRF, 1 E, 2 M)
//   md_busy    out  : mult/div unit occupied
//   stall_cnt  out 32: stall cycle count, present only with STALL_CNT_EN
// Optional feature macro: STALL_CNT_EN.
// -----------------------------------------------------------------------------
module d_stall_ctrl
    import d_stall_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic [4:0]  d_wa,
    input  logic [1:0]  d_tnew,
    input  logic        d_md,
    input  logic        e_md_start,
    input  logic        e_md_div,
    output logic        stall,
    output logic [1:0]  fwd_cmp_a,
    output logic [1:0]  fwd_cmp_b,
    output logic        md_busy
`ifdef STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    stage_t e_q, e_d;
    stage_t m_q, m_d;

    logic [4:0] src  [2];
    logic [1:0] tuse [2];
    logic [1:0] haz;
    fwd_sel_e   fwd_sel [2];

    assign src[0]  = d_rs;
    assign src[1]  = d_rt;
    assign tuse[0] = d_tuse_rs;
    assign tuse[1] = d_tuse_rt;

    md_busy_ctr u_md_busy_ctr (
        .clk   (clk),
        .reset (reset),
        .start (e_md_start),
        .div   (e_md_div),
        .busy  (md_busy)
    );

    // Per-operand hazard and forwarding. Register 0 never matches, so a
    // producer writing $0 is invisible. Everything is derived from shadow
    // state, so the selects stay valid while D is frozen.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            logic e_hit;
            logic m_hit;

            assign e_hit = (src[gi] != 5'd0) && (e_q.wa == src[gi]);
            assign m_hit = (src[gi] != 5'd0) && (m_q.wa == src[gi]);

            assign haz[gi] = (tuse[gi] != TUSE_NONE) &&
                             ((e_hit && (e_q.tnew > tuse[gi])) ||
                              (m_hit && (m_q.tnew > tuse[gi])));

            // E is the younger producer, so it wins over M.
            assign fwd_sel[gi] = (e_hit && (e_q.tnew == 2'd0)) ? FWD_E :
                                 (m_hit && (m_q.tnew == 2'd0)) ? FWD_M :
                                                                 FWD_GRF;
        end
    endgenerate

    assign stall     = (|haz) | (d_md & md_busy);
    assign fwd_cmp_a = fwd_sel[0];
    assign fwd_cmp_b = fwd_sel[1];

    always_comb begin
        e_d = stall ? '0 : stage_t'{wa: d_wa, tnew: d_tnew};
        m_d = stage_t'{wa: e_q.wa, tnew: tnew_dec(e_q.tnew)};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q <= '0;
            m_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
        end
    end

`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    // Free-running; wraps naturally at 2^32.
    assign stall_cnt_d = stall_cnt_q + {31'd0, stall};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_d_stall_ctrl.sv
module tb_d_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  d_rs = '0, d_rt = '0, d_wa = '0;
    logic [1:0]  d_tuse_rs = 2'd3, d_tuse_rt = 2'd3, d_tnew = '0;
    logic        d_md = 1'b0, e_md_start = 1'b0, e_md_div = 1'b0;
    logic        stall, md_busy;
    logic [1:0]  fwd_cmp_a, fwd_cmp_b;
`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    d_stall_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_wa       (d_wa),
        .d_tnew     (d_tnew),
        .d_md       (d_md),
        .e_md_start (e_md_start),
        .e_md_div   (e_md_div),
        .stall      (stall),
        .fwd_cmp_a  (fwd_cmp_a),
        .fwd_cmp_b  (fwd_cmp_b),
        .md_busy    (md_busy)
`ifdef STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // History of instructions that entered E: entry i has been in flight for
    // i cycles (0 = now in E, 1 = now in M). A result needs tnew cycles after
    // entering E, so its remaining wait is max(tnew - age, 0).
    typedef struct packed {
        logic [4:0] wa;
        logic [1:0] tnew;
    } prod_t;

    prod_t       pipe[$];
    int unsigned cyc = 0;
    int unsigned last_start = 0;
    int unsigned last_lat = 0;
    bit          md_valid = 0;
    int unsigned m_stall_cnt = 0;

    int checks = 0;
    int errors = 0;

    function automatic int remaining(input int age);
        int t;
        t = int'(pipe[age].tnew) - age;
        return (t > 0) ? t : 0;
    endfunction

    function automatic bit m_haz(input logic [4:0] src, input logic [1:0] tuse);
        if (src == 5'd0 || tuse == 2'd3) return 1'b0;
        for (int i = 0; i < 2; i++)
            if (pipe[i].wa == src && remaining(i) > int'(tuse)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        if (src == 5'd0) return 2'd0;
        for (int i = 0; i < 2; i++)
            if (pipe[i].wa == src && remaining(i) == 0) return 2'(i + 1);
        return 2'd0;
    endfunction

    // Busy on the issue cycle and for 'lat' cycles after it; only the most
    // recent issue matters because a new one restarts the unit.
    function automatic bit m_busy(input logic st);
        if (st) return 1'b1;
        return md_valid && ((cyc - last_start) <= last_lat);
    endfunction

    task automatic model_reset();
        prod_t z;
        z = '0;
        pipe.delete();
        pipe.push_back(z);
        pipe.push_back(z);
        md_valid = 0;
        m_stall_cnt = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive D/E inputs, compare against the model,
    // then advance the model across the rising edge.
    task automatic cycle(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] tur, input logic [1:0] tut,
                         input logic [4:0] wa, input logic [1:0] tn,
                         input logic md, input logic st, input logic dv,
                         output logic o_stall, output logic [1:0] o_fa,
                         output logic [1:0] o_fb, output logic o_busy);
        logic       e_stall, e_busy;
        logic [1:0] e_fa, e_fb;
        prod_t      p;
        @(negedge clk);
        d_rs = rs; d_rt = rt; d_tuse_rs = tur; d_tuse_rt = tut;
        d_wa = wa; d_tnew = tn; d_md = md; e_md_start = st; e_md_div = dv;
        #1;
        e_busy  = m_busy(st);
        e_stall = m_haz(rs, tur) | m_haz(rt, tut) | (md & e_busy);
        e_fa    = m_fwd(rs);
        e_fb    = m_fwd(rt);
        check("stall", {31'd0, stall}, {31'd0, e_stall});
        check("fwd_cmp_a", {30'd0, fwd_cmp_a}, {30'd0, e_fa});
        check("fwd_cmp_b", {30'd0, fwd_cmp_b}, {30'd0, e_fb});
        check("md_busy", {31'd0, md_busy}, {31'd0, e_busy});
`ifdef STALL_CNT_EN
        check("stall_cnt", stall_cnt, m_stall_cnt);
`endif
        o_stall = stall; o_fa = fwd_cmp_a; o_fb = fwd_cmp_b; o_busy = md_busy;
        $display("cyc=%0d rs=%0d rt=%0d tuse=%0d/%0d wa=%0d tnew=%0d md=%b start=%b div=%b -> stall=%b fa=%0d fb=%0d busy=%b",
                 cyc, rs, rt, tur, tut, wa, tn, md, st, dv, stall, fwd_cmp_a, fwd_cmp_b, md_busy);
        @(posedge clk);
        if (st) begin
            md_valid   = 1;
            last_start = cyc;
            last_lat   = dv ? 10 : 5;
        end
        cyc++;
        p.wa   = e_stall ? 5'd0 : wa;
        p.tnew = e_stall ? 2'd0 : tn;
        pipe.push_front(p);
        void'(pipe.pop_back());
        if (e_stall) m_stall_cnt++;
    endtask

    task automatic nops(input int n);
        logic s, b;
        logic [1:0] fa, fb;
        for (int i = 0; i < n; i++)
            cycle(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, s, fa, fb, b);
    endtask

    initial begin
        logic       s, b;
        logic [1:0] fa, fb;
        int         n;

        model_reset();

        // Reset state while reset is held low.
        #2;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_fwd_a", {30'd0, fwd_cmp_a}, 32'd0);
        check("rst_fwd_b", {30'd0, fwd_cmp_b}, 32'd0);
        check("rst_busy", {31'd0, md_busy}, 32'd0);
`ifdef STALL_CNT_EN
        check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;

        // Load-use into a branch: two stall cycles, then operand comes from GRF.
        nops(3);
        cycle(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0, s, fa, fb, b);
        check("lw_issue_stall", {31'd0, s}, 32'd0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(5'd1, 5'd2, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, s, fa, fb, b);
            if (!s) break;
            n++;
        end
        check("lw_beq_stall_cycles", n, 32'd2);
        check("lw_beq_fwd_a", {30'd0, fa}, 32'd0);

        // ALU result into a branch: one stall, then forwarded from M.
        nops(2);
        cycle(5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0, s, fa, fb, b);
        cycle(5'd3, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, s, fa, fb, b);
        check("addu_bne_stall", {31'd0, s}, 32'd1);
        cycle(5'd3, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, s, fa, fb, b);
        check("addu_bne_release", {31'd0, s}, 32'd0);
        check("addu_bne_fwd_a", {30'd0, fa}, 32'd2);
        check("addu_bne_fwd_b", {30'd0, fb}, 32'd0);

        // lui (tnew=0) into beq $4,$4: no stall, both operands from E.
        nops(2);
        cycle(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd0, 1'b0, 1'b0, 1'b0, s, fa, fb, b);
        cycle(5'd4, 5'd4, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, s, fa, fb, b);
        check("lui_beq_stall", {31'd0, s}, 32'd0);
        check("lui_beq_fwd_a", {30'd0, fa}, 32'd1);
        check("lui_beq_fwd_b", {30'd0, fb}, 32'd1);

        // div issue with mfhi waiting in D: 11 stall cycles including issue.
        nops(12);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, (i == 0), 1'b1, s, fa, fb, b);
            if (!s) break;
            n++;
        end
        check("div_mfhi_stall_cycles", n, 32'd11);
        check("div_mfhi_busy_after", {31'd0, b}, 32'd0);

        // Producer writing $0 never causes a hazard or a forward.
        nops(2);
        cycle(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0, s, fa, fb, b);
        cycle(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, s, fa, fb, b);
        check("zero_reg_stall", {31'd0, s}, 32'd0);
        check("zero_reg_fwd_a", {30'd0, fa}, 32'd0);
        check("zero_reg_fwd_b", {30'd0, fb}, 32'd0);

        // Restart: mult issued while a div is still running.
        nops(2);
        cycle(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b1, 1'b1, s, fa, fb, b);
        nops(3);
        cycle(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0, s, fa, fb, b);
        nops(7);

        // Randomized traffic on a small register set to provoke collisions.
        for (int i = 0; i < 300; i++) begin
            cycle(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 1)), s, fa, fb, b);
        end

        // Asynchronous reset in the middle of a div and a load-use stall.
        nops(12);
        cycle(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b1, 1'b1, s, fa, fb, b);
        cycle(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0, s, fa, fb, b);
        @(negedge clk);
        d_rs = 5'd5; d_rt = 5'd0; d_tuse_rs = 2'd0; d_tuse_rt = 2'd3;
        d_wa = 5'd0; d_tnew = 2'd0; d_md = 1'b1; e_md_start = 1'b0; e_md_div = 1'b0;
        #1;
        check("pre_rst_stall", {31'd0, stall}, 32'd1);
        check("pre_rst_busy", {31'd0, md_busy}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        check("mid_rst_busy", {31'd0, md_busy}, 32'd0);
        check("mid_rst_fwd_a", {30'd0, fwd_cmp_a}, 32'd0);
`ifdef STALL_CNT_EN
        check("mid_rst_stall_cnt", stall_cnt, 32'd0);
`endif
        e_md_start = 1'b1;
        #1;
        check("rst_start_busy", {31'd0, md_busy}, 32'd1);
        check("rst_start_stall", {31'd0, stall}, 32'd1);
        e_md_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        d_rs = '0; d_tuse_rs = 2'd3; d_md = 1'b0;
        model_reset();
        reset = 1'b1;
        // The abandoned div must not resurface.
        cycle(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, s, fa, fb, b);
        check("post_rst_busy", {31'd0, b}, 32'd0);
        check("post_rst_stall", {31'd0, s}, 32'd0);
        nops(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
